// File: rtl/mem_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_stage_if : EX/MEM request and MEM/WB result bus of the mem stage   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mem_stage_if;
  logic        reg_write_en_i;
  logic        mem_write_en_i;
  logic        mem_read_en_i;
  logic [63:0] reg_data1_i;
  logic [63:0] reg_data2_i;
  logic [4:0]  reg_write_data_i;
  logic        reg_write_en_o;
  logic [4:0]  reg_write_data_o;
  logic [63:0] wb_data_o;
  logic        mem_err_o;
  logic [31:0] store_cnt_o;
  logic [31:0] load_cnt_o;

  modport master (
    output reg_write_en_i, mem_write_en_i, mem_read_en_i,
           reg_data1_i, reg_data2_i, reg_write_data_i,
    input  reg_write_en_o, reg_write_data_o, wb_data_o,
           mem_err_o, store_cnt_o, load_cnt_o
  );

  modport slave (
    input  reg_write_en_i, mem_write_en_i, mem_read_en_i,
           reg_data1_i, reg_data2_i, reg_write_data_i,
    output reg_write_en_o, reg_write_data_o, wb_data_o,
           mem_err_o, store_cnt_o, load_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_stage : pipeline memory stage with 64-bit data RAM, error flag and |
// | store/load counters. MEM_STAGE_FWD_EN adds a store->load bypass.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mem_stage #(
  parameter int DEPTH = 256
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];

  logic          reg_write_en_q, reg_write_en_d;
  logic [4:0]    reg_write_data_q, reg_write_data_d;
  logic [63:0]   wb_data_q, wb_data_d;
  logic          mem_err_q, mem_err_d;
  logic [31:0]   store_cnt_q, store_cnt_d;
  logic [31:0]   load_cnt_q, load_cnt_d;

  logic [AW-1:0] w_idx;
  logic          w_addr_ok;
  logic          w_illegal;
  logic          w_ld_ok;
  logic          w_st_ok;
  logic [63:0]   w_rd_data;

  assign w_idx     = bus.reg_data1_i[AW+2:3];
  assign w_addr_ok = (bus.reg_data1_i[2:0] == 3'b000) && !(|bus.reg_data1_i[63:AW+3]);
  assign w_illegal = ((bus.mem_read_en_i || bus.mem_write_en_i) && !w_addr_ok)
                   || (bus.mem_read_en_i && bus.mem_write_en_i);
  assign w_ld_ok   = bus.mem_read_en_i && !bus.mem_write_en_i && w_addr_ok;
  assign w_st_ok   = bus.mem_write_en_i && !bus.mem_read_en_i && w_addr_ok;

`ifdef MEM_STAGE_FWD_EN
  logic          fwd_vld_q;
  logic [AW-1:0] fwd_idx_q;
  logic [63:0]   fwd_data_q;

  // Bypass keeps store->load correct if the RAM ever gets a registered write port.
  assign w_rd_data = (fwd_vld_q && (fwd_idx_q == w_idx)) ? fwd_data_q : mem_q[w_idx];
`else
  assign w_rd_data = mem_q[w_idx];
`endif

  always_comb begin
    reg_write_en_d   = bus.reg_write_en_i;
    reg_write_data_d = bus.reg_write_data_i;
    wb_data_d        = bus.reg_data1_i;
    mem_err_d        = mem_err_q;
    store_cnt_d      = store_cnt_q;
    load_cnt_d       = load_cnt_q;
    if (w_illegal) begin
      mem_err_d = 1'b1;
      // Any rejected read, including read+write, must not write back.
      if (bus.mem_read_en_i) begin
        wb_data_d      = '0;
        reg_write_en_d = 1'b0;
      end
    end else if (w_ld_ok) begin
      wb_data_d = w_rd_data;
      if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_d = load_cnt_q + 32'd1;
    end else if (w_st_ok) begin
      if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_en_q   <= 1'b0;
      reg_write_data_q <= '0;
      wb_data_q        <= '0;
      mem_err_q        <= 1'b0;
      store_cnt_q      <= '0;
      load_cnt_q       <= '0;
`ifdef MEM_STAGE_FWD_EN
      fwd_vld_q        <= 1'b0;
      fwd_idx_q        <= '0;
      fwd_data_q       <= '0;
`endif
    end else begin
      reg_write_en_q   <= reg_write_en_d;
      reg_write_data_q <= reg_write_data_d;
      wb_data_q        <= wb_data_d;
      mem_err_q        <= mem_err_d;
      store_cnt_q      <= store_cnt_d;
      load_cnt_q       <= load_cnt_d;
      if (w_st_ok) mem_q[w_idx] <= bus.reg_data2_i;
`ifdef MEM_STAGE_FWD_EN
      fwd_vld_q        <= w_st_ok;
      fwd_idx_q        <= w_idx;
      fwd_data_q       <= bus.reg_data2_i;
`endif
    end
  end

  assign bus.reg_write_en_o   = reg_write_en_q;
  assign bus.reg_write_data_o = reg_write_data_q;
  assign bus.wb_data_o        = wb_data_q;
  assign bus.mem_err_o        = mem_err_q;
  assign bus.store_cnt_o      = store_cnt_q;
  assign bus.load_cnt_o       = load_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Self-checking bench for mem_stage: directed vector table, async-reset and
// sticky-error sequences, then random traffic against a behavioural model.
module tb_mem_stage;
  localparam int DEPTH = 256;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_stage_if bus();
  mem_stage #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          re, we, rwe;
    logic [63:0] a, d;
    logic [4:0]  dst;
    logic [63:0] e_wb;
    bit          e_rwe, e_err;
    int unsigned e_sc, e_lc;
  } vec_t;
  vec_t vt[16];

  // behavioural model state
  logic [63:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  logic [63:0] m_wb;
  bit          m_wbx, m_rwe, m_err;
  logic [4:0]  m_dst;
  int unsigned m_sc, m_lc;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit re, input bit we, input bit rwe,
                       input logic [63:0] a, input logic [63:0] d, input logic [4:0] dst);
    bus.mem_read_en_i    = re;
    bus.mem_write_en_i   = we;
    bus.reg_write_en_i   = rwe;
    bus.reg_data1_i      = a;
    bus.reg_data2_i      = d;
    bus.reg_write_data_i = dst;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_rwe"}, 64'(bus.reg_write_en_o), 64'd0);
    cmp({tag, "_dst"}, 64'(bus.reg_write_data_o), 64'd0);
    cmp({tag, "_wb"},  bus.wb_data_o, 64'd0);
    cmp({tag, "_err"}, 64'(bus.mem_err_o), 64'd0);
    cmp({tag, "_sc"},  64'(bus.store_cnt_o), 64'd0);
    cmp({tag, "_lc"},  64'(bus.load_cnt_o), 64'd0);
  endtask

  task automatic model_reset();
    m_wb = '0; m_wbx = 1'b0; m_rwe = 1'b0; m_err = 1'b0; m_dst = '0; m_sc = 0; m_lc = 0;
  endtask

  // Resets with the bench sitting just after a rising edge; checks outputs clear at once.
  task automatic do_reset(input string tag);
    drive(0, 0, 0, 64'd0, 64'd0, 5'd0);
    rst_i = 1'b0;
    #1;
    check_zero(tag);
    tick();
    rst_i = 1'b1;
    model_reset();
  endtask

  task automatic model_step();
    logic [63:0] a;
    bit ok, re, we;
    int unsigned w;
    a  = bus.reg_data1_i;
    re = bus.mem_read_en_i;
    we = bus.mem_write_en_i;
    ok = (a % 64'd8 == 64'd0) && (a < 64'(DEPTH) * 64'd8);
    w  = ok ? int'(a / 64'd8) : 0;
    m_dst = bus.reg_write_data_i;
    m_rwe = bus.reg_write_en_i;
    m_wbx = 1'b0;
    if ((re || we) && (!ok || (re && we))) begin
      m_err = 1'b1;
      if (re) begin
        m_wb  = '0;
        m_rwe = 1'b0;
      end else m_wb = a;
    end else if (re) begin
      m_wb  = m_mem[w];
      m_wbx = !m_val[w];
      if (m_lc != 32'hFFFF_FFFF) m_lc++;
    end else begin
      m_wb = a;
      if (we) begin
        m_mem[w] = bus.reg_data2_i;
        m_val[w] = 1'b1;
        if (m_sc != 32'hFFFF_FFFF) m_sc++;
      end
    end
  endtask

  task automatic check_model();
    cmp("rnd_rwe", 64'(bus.reg_write_en_o), 64'(m_rwe));
    cmp("rnd_dst", 64'(bus.reg_write_data_o), 64'(m_dst));
    if (!m_wbx) cmp("rnd_wb", bus.wb_data_o, m_wb);
    cmp("rnd_err", 64'(bus.mem_err_o), 64'(m_err));
    cmp("rnd_sc",  64'(bus.store_cnt_o), 64'(m_sc));
    cmp("rnd_lc",  64'(bus.load_cnt_o), 64'(m_lc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          re we rwe a                       d                        dst   e_wb                     rwe err sc lc
    vt[0]  = '{0, 1, 0, 64'h10,                   64'hDEAD_BEEF_0000_0001, 5'd0, 64'h10,                  0, 0, 1, 0};
    vt[1]  = '{1, 0, 1, 64'h10,                   64'h0,                   5'd5, 64'hDEAD_BEEF_0000_0001, 1, 0, 1, 1};
    vt[2]  = '{0, 0, 1, 64'h1234,                 64'h0,                   5'd7, 64'h1234,                1, 0, 1, 1};
    vt[3]  = '{0, 1, 0, 64'h40,                   64'hA5,                  5'd0, 64'h40,                  0, 0, 2, 1};
    vt[4]  = '{1, 0, 1, 64'h40,                   64'h0,                   5'd3, 64'hA5,                  1, 0, 2, 2};
    vt[5]  = '{0, 1, 0, 64'h0,                    64'h55,                  5'd0, 64'h0,                   0, 0, 3, 2};
    vt[6]  = '{1, 0, 1, 64'h0,                    64'h0,                   5'd1, 64'h55,                  1, 0, 3, 3};
    vt[7]  = '{1, 0, 1, 64'h13,                   64'h0,                   5'd9, 64'h0,                   0, 1, 3, 3};
    vt[8]  = '{0, 1, 0, 64'h800,                  64'h77,                  5'd0, 64'h800,                 0, 1, 3, 3};
    vt[9]  = '{1, 0, 1, 64'h0,                    64'h0,                   5'd2, 64'h55,                  1, 1, 3, 4};
    vt[10] = '{1, 1, 1, 64'h40,                   64'hFF,                  5'd4, 64'h0,                   0, 1, 3, 4};
    vt[11] = '{1, 0, 1, 64'h40,                   64'h0,                   5'd6, 64'hA5,                  1, 1, 3, 5};
    vt[12] = '{0, 1, 0, 64'h7F8,                  64'h1234_5678,           5'd0, 64'h7F8,                 0, 1, 4, 5};
    vt[13] = '{1, 0, 1, 64'h7F8,                  64'h0,                   5'd8, 64'h1234_5678,           1, 1, 4, 6};
    vt[14] = '{0, 1, 0, 64'h8000_0000_0000_0000,  64'h1,                   5'd0, 64'h8000_0000_0000_0000, 0, 1, 4, 6};
    vt[15] = '{1, 0, 1, 64'h0,                    64'h0,                   5'd2, 64'h55,                  1, 1, 4, 7};

    drive(0, 0, 0, 64'd0, 64'd0, 5'd0);
    #1;
    check_zero("por");
    tick();
    rst_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].re, vt[i].we, vt[i].rwe, vt[i].a, vt[i].d, vt[i].dst);
      tick();
      cmp($sformatf("vec%0d_wb", i),  bus.wb_data_o, vt[i].e_wb);
      cmp($sformatf("vec%0d_rwe", i), 64'(bus.reg_write_en_o), 64'(vt[i].e_rwe));
      cmp($sformatf("vec%0d_dst", i), 64'(bus.reg_write_data_o), 64'(vt[i].dst));
      cmp($sformatf("vec%0d_err", i), 64'(bus.mem_err_o), 64'(vt[i].e_err));
      cmp($sformatf("vec%0d_sc", i),  64'(bus.store_cnt_o), 64'(vt[i].e_sc));
      cmp($sformatf("vec%0d_lc", i),  64'(bus.load_cnt_o), 64'(vt[i].e_lc));
    end

    // misaligned load sets the error flag, which stays set through legal traffic
    do_reset("rst1");
    drive(1, 0, 1, 64'h13, 64'd0, 5'd9);
    tick();
    cmp("mis_wb", bus.wb_data_o, 64'd0);
    cmp("mis_rwe", 64'(bus.reg_write_en_o), 64'd0);
    cmp("mis_err", 64'(bus.mem_err_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 64'(i) * 64'h111, 64'd0, 5'd7);
      tick();
    end
    cmp("mis_err_sticky", 64'(bus.mem_err_o), 64'd1);
    cmp("mis_wb_after", bus.wb_data_o, 64'h999);

    // both enables: rejected, writeback suppressed, no counting
    do_reset("rst2");
    drive(1, 1, 1, 64'h40, 64'h1, 5'd4);
    tick();
    cmp("both_err", 64'(bus.mem_err_o), 64'd1);
    cmp("both_rwe", 64'(bus.reg_write_en_o), 64'd0);
    cmp("both_wb", bus.wb_data_o, 64'd0);
    cmp("both_cnt", {bus.store_cnt_o, bus.load_cnt_o}, 64'd0);

    // async reset mid-cycle after three stores; memory survives, in-reset store dropped
    do_reset("rst3");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 64'h100 + 64'(i) * 64'd8, 64'hC0DE_0000 + 64'(i), 5'd0);
      tick();
    end
    cmp("pre_async_sc", 64'(bus.store_cnt_o), 64'd3);
    drive(0, 0, 1, 64'h5555, 64'd0, 5'd3);
    #2;
    rst_i = 1'b0;
    #1;
    check_zero("async");
    drive(0, 1, 0, 64'h100, 64'hBAD, 5'd0);
    tick();
    cmp("inrst_sc", 64'(bus.store_cnt_o), 64'd0);
    rst_i = 1'b1;
    drive(1, 0, 1, 64'h100, 64'd0, 5'd10);
    tick();
    cmp("post_rst_wb", bus.wb_data_o, 64'hC0DE_0000);
    cmp("post_rst_dst", 64'(bus.reg_write_data_o), 64'd10);
    cmp("post_rst_cnt", {bus.store_cnt_o, bus.load_cnt_o}, {32'd0, 32'd1});

    // random traffic against the model
    do_reset("rst4");
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      int unsigned r, op;
      logic [63:0] a;
      if (n % 100 == 99) begin
        do_reset("rst_rnd");
        continue;
      end
      r  = $urandom_range(0, 59);
      op = $urandom_range(0, 3);
      a  = {$urandom, $urandom};
      if (op == 1 || op == 2) begin
        if (r == 0)      a = {53'd0, 8'($urandom_range(0, 15)), 3'($urandom_range(1, 7))};
        else if (r == 1) a = 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 4095)) * 64'd8;
        else             a = 64'($urandom_range(0, 15)) * 64'd8;
      end
      drive(op == 2 || (op == 1 && r == 2), op == 1, 1'($urandom), a,
            {$urandom, $urandom}, 5'($urandom));
      model_step();
      tick();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256, data-memory depth in 64-bit words; power of two, 2..4096.
REQ-002 Derived AW = log2(DEPTH), word-index width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous active-low reset: asserted on low level, independent of clk_i; released synchronously to clk_i by the integration.
REQ-005 reg_write_en_i  input  1  writeback enable from the EX/MEM register.
REQ-006 mem_write_en_i  input  1  store request.
REQ-007 mem_read_en_i  input  1  load request.
REQ-008 reg_data1_i  input  64  ALU result / byte address.
REQ-009 reg_data2_i  input  64  store data.
REQ-010 reg_write_data_i  input  5  destination register index.
REQ-011 reg_write_en_o  output  1  registered writeback enable to WB.
REQ-012 reg_write_data_o  output  5  registered destination index.
REQ-013 wb_data_o  output  64  registered writeback value.
REQ-014 mem_err_o  output  1  sticky access-error flag.
REQ-015 store_cnt_o  output  32  saturating count of committed stores.
REQ-016 load_cnt_o  output  32  saturating count of committed loads.

Function
REQ-017 Address decode: word index = reg_data1_i[AW+2:3]; misaligned = reg_data1_i[2:0] != 0; out-of-range = any bit of reg_data1_i[63:AW+3] set.
REQ-018 Access is legal only if it is neither misaligned nor out-of-range; illegal access = load or store request with an illegal address, or mem_read_en_i and mem_write_en_i both high.
REQ-019 Legal store: the memory word is written at the rising edge at which the request is sampled; store_cnt_o increments at that edge.
REQ-020 Legal load: the memory word is read synchronously; wb_data_o holds the word after the sampling edge, for a latency of 1 cycle; load_cnt_o increments at that edge.
REQ-021 Non-load cycle: wb_data_o <= reg_data1_i at the edge, for a latency of 1 cycle.
REQ-022 reg_write_en_o and reg_write_data_o are the 1-cycle registered copies of their inputs, every cycle.
REQ-023 Illegal access: no memory write; no counter change; mem_err_o <= 1.
REQ-024 Illegal access that is a load: wb_data_o <= 0 and reg_write_en_o <= 0.
REQ-025 Both enables high: treated as illegal per REQ-023/024, including the writeback suppression.
REQ-026 mem_err_o stays 1 until reset.
REQ-027 Counters stop at 0xFFFF_FFFF and do not wrap.
REQ-028 Memory contents are not reset; a read of a never-written word returns X in simulation.

Reset
REQ-029 While rst_i is low, all outputs read as follows: reg_write_en_o=0, reg_write_data_o=0, wb_data_o=0, mem_err_o=0, store_cnt_o=0, load_cnt_o=0.
REQ-030 A request sampled while rst_i is low is dropped: no memory write, no count.
REQ-031 Reset asserted mid-sequence clears all outputs and counters immediately; memory contents are retained.

Configuration
REQ-032 Macro MEM_STAGE_FWD_EN selects load-after-store forwarding.
REQ-033 Defined: when a legal load is sampled one cycle after a legal store to the same word, wb_data_o returns the stored data.
REQ-034 Undefined: that case also returns the stored data, because the write commits one edge before the read (REQ-019); the macro adds a write-data bypass register and compare so that this holds for memory macros with registered write. All other behaviour is identical with or without the macro.

Verification
REQ-035 Scenario 1: rst_i low, then store of 0xDEAD_BEEF_0000_0001 to address 0x10, then load from 0x10 with dest=5 -> reg_write_en_o=1, reg_write_data_o=5, wb_data_o=0xDEAD_BEEF_0000_0001 one cycle after the load; store_cnt_o=1, load_cnt_o=1.
REQ-036 Scenario 2: non-memory op with reg_data1_i=0x1234 and dest=7 -> wb_data_o=0x1234 and reg_write_data_o=7 the next cycle; counters unchanged.
REQ-037 Scenario 3: load from 0x13 (misaligned) -> wb_data_o=0, reg_write_en_o=0, mem_err_o=1; mem_err_o still 1 after 10 further legal cycles.
REQ-038 Scenario 4: DEPTH=256, store to 0x800 (out of range), then load from 0x0 -> word 0 unchanged and mem_err_o=1.
REQ-039 Scenario 5: back-to-back store of 0xA5 to 0x40 and load from 0x40, with and without MEM_STAGE_FWD_EN -> wb_data_o=0xA5 in both builds.
REQ-040 Scenario 6: rst_i pulsed low asynchronously between edges after 3 stores -> counters and outputs 0 immediately, without waiting for a clock edge; a subsequent load of the first stored address returns the previously stored data.
